// File: rtl/comet_ii_fetch_sequencer.sv
// COMET II fetch front end: owns PR, the fetch handshake and the instruction
// register, and sequences the 3-bit CPU state consumed by the decoder.
module comet_ii_fetch_sequencer #(
  parameter logic [15:0] RESET_PR       = 16'h0000,
  parameter bit          AUTO_START     = 1'b0,
  parameter bit          USE_START_ADDR = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] start_addr,
  input  logic        halt,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  input  logic        exec_done,
  input  logic        pr_load,
  input  logic [15:0] pr_load_val,
  output logic [2:0]  state,
  output logic [7:0]  op_code,
  output logic [7:0]  regs,
  output logic [15:0] adr,
  output logic        adr_en,
  output logic [15:0] pr,
  output logic        illegal_op
);

  // Encoding is consumed bit-for-bit by the decoder; do not reorder.
  typedef enum logic [2:0] {
    S_IDLE  = 3'b000,
    S_INIT  = 3'b001,
    S_IFET1 = 3'b010,
    S_IFET2 = 3'b011,
    S_EXEC  = 3'b100,
    S_WBACK = 3'b101
  } state_t;

  state_t cur_st, nxt_st;

  function automatic logic is_two_word(input logic [7:0] op);
    return (op[7:4] == 4'h6) ||
           (!op[2] && (op != 8'h00) && (op != 8'h71) && (op != 8'h81));
  endfunction

  function automatic logic is_legal(input logic [7:0] op);
    logic ok;
    case (op)
      8'h00, 8'h10, 8'h11, 8'h12, 8'h14,
      8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27,
      8'h30, 8'h31, 8'h32, 8'h34, 8'h35, 8'h36,
      8'h40, 8'h41, 8'h44, 8'h45,
      8'h50, 8'h51, 8'h52, 8'h53,
      8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66,
      8'h70, 8'h71, 8'h80, 8'h81, 8'hF0: ok = 1'b1;
      default:                           ok = 1'b0;
    endcase
    return ok;
  endfunction

  logic [7:0] fetch_op;
  logic       fetch_tw;
  logic       ifet1_done, ifet2_done, exec_fire;

  assign fetch_op   = mem_rdata[15:8];
  assign fetch_tw   = is_two_word(fetch_op);
  assign ifet1_done = (cur_st == S_IFET1) && mem_ready;
  assign ifet2_done = (cur_st == S_IFET2) && mem_ready;
  assign exec_fire  = (cur_st == S_EXEC) && exec_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur_st <= S_IDLE;
    else        cur_st <= nxt_st;
  end

  always_comb begin
    nxt_st = cur_st;
    case (cur_st)
      S_IDLE:  if (start || AUTO_START) nxt_st = S_INIT;
      S_INIT:  nxt_st = S_IFET1;
      S_IFET1: if (mem_ready) nxt_st = fetch_tw ? S_IFET2 : S_EXEC;
      S_IFET2: if (mem_ready) nxt_st = S_EXEC;
      S_EXEC:  if (exec_done) nxt_st = S_WBACK;
      S_WBACK: nxt_st = halt ? S_IDLE : S_IFET1;
      default: nxt_st = S_IDLE;
    endcase
  end

  // PR: entry load, post-increment on each fetched word (wraps), branch load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pr <= RESET_PR;
    end else if (cur_st == S_INIT) begin
      pr <= USE_START_ADDR ? start_addr : RESET_PR;
    end else if (ifet1_done || ifet2_done) begin
      pr <= pr + 16'd1;
    end else if (exec_fire && pr_load) begin
      pr <= pr_load_val;
    end
  end

  // Instruction register holds through EXEC/WBACK until the next first word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_code    <= '0;
      regs       <= '0;
      adr        <= '0;
      adr_en     <= 1'b0;
      illegal_op <= 1'b0;
    end else if (ifet1_done) begin
      op_code    <= fetch_op;
      regs       <= mem_rdata[7:0];
      adr        <= '0;
      adr_en     <= fetch_tw;
      illegal_op <= !is_legal(fetch_op);
    end else if (ifet2_done) begin
      adr <= mem_rdata;
    end
  end

  assign state    = cur_st;
  assign mem_rd   = (cur_st == S_IFET1) || (cur_st == S_IFET2);
  assign mem_addr = pr;

endmodule

// File: tb/tb_comet_ii_fetch_sequencer.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a spec-level behavioural model.
module tb_comet_ii_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] start_addr;
  logic        halt;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic        exec_done;
  logic        pr_load;
  logic [15:0] pr_load_val;
  logic [2:0]  state;
  logic [7:0]  op_code;
  logic [7:0]  regs;
  logic [15:0] adr;
  logic        adr_en;
  logic [15:0] pr;
  logic        illegal_op;

  comet_ii_fetch_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
    .halt(halt), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .exec_done(exec_done), .pr_load(pr_load),
    .pr_load_val(pr_load_val), .state(state), .op_code(op_code), .regs(regs),
    .adr(adr), .adr_en(adr_en), .pr(pr), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:65535];
  assign mem_rdata = mem[mem_addr];

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
  endtask

  // ---- behavioural model, written from the spec's rules ----
  localparam logic [2:0] P_IDLE = 3'd0, P_INIT = 3'd1, P_IFET1 = 3'd2,
                         P_IFET2 = 3'd3, P_EXEC = 3'd4, P_WBACK = 3'd5;

  function automatic bit spec_two_word(input logic [7:0] op);
    return (op[7:4] == 4'h6) || (op[2] == 1'b0 && !(op inside {8'h00, 8'h71, 8'h81}));
  endfunction

  function automatic bit spec_legal(input logic [7:0] op);
    return op inside {8'h00, [8'h10:8'h12], 8'h14, [8'h20:8'h27], [8'h30:8'h32],
                      [8'h34:8'h36], 8'h40, 8'h41, 8'h44, 8'h45, [8'h50:8'h53],
                      [8'h61:8'h66], 8'h70, 8'h71, 8'h80, 8'h81, 8'hF0};
  endfunction

  logic [2:0]  m_phase;
  logic [15:0] m_pr, m_adr;
  logic [7:0]  m_op, m_regs;
  logic        m_adr_en, m_ill;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= P_IDLE; m_pr <= 16'h0000; m_op <= 8'h00; m_regs <= 8'h00;
      m_adr <= 16'h0000; m_adr_en <= 1'b0; m_ill <= 1'b0;
    end else begin
      case (m_phase)
        P_IDLE:  if (start) m_phase <= P_INIT;
        P_INIT:  begin m_pr <= start_addr; m_phase <= P_IFET1; end
        P_IFET1: if (mem_ready) begin
          m_op     <= mem[m_pr][15:8];
          m_regs   <= mem[m_pr][7:0];
          m_adr    <= 16'h0000;
          m_adr_en <= spec_two_word(mem[m_pr][15:8]);
          m_ill    <= !spec_legal(mem[m_pr][15:8]);
          m_pr     <= m_pr + 16'd1;
          m_phase  <= spec_two_word(mem[m_pr][15:8]) ? P_IFET2 : P_EXEC;
        end
        P_IFET2: if (mem_ready) begin
          m_adr <= mem[m_pr]; m_pr <= m_pr + 16'd1; m_phase <= P_EXEC;
        end
        P_EXEC:  if (exec_done) begin
          if (pr_load) m_pr <= pr_load_val;
          m_phase <= P_WBACK;
        end
        default: m_phase <= halt ? P_IDLE : P_IFET1;
      endcase
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    chk("m.state", state, m_phase);
    chk("m.mem_rd", mem_rd, (m_phase == P_IFET1 || m_phase == P_IFET2));
    chk("m.mem_addr", mem_addr, m_pr);
    chk("m.pr", pr, m_pr);
    chk("m.op_code", op_code, m_op);
    chk("m.regs", regs, m_regs);
    chk("m.adr", adr, m_adr);
    chk("m.adr_en", adr_en, m_adr_en);
    chk("m.illegal_op", illegal_op, m_ill);
  end

  task automatic nxt();
    @(negedge clk);
  endtask

  // EXEC completes with a branch, then WBACK -> IFET1.
  task automatic exec_jump(input logic [15:0] tgt);
    exec_done = 1'b1; pr_load = 1'b1; pr_load_val = tgt;
    nxt();
    exec_done = 1'b0; pr_load = 1'b0;
    nxt();
  endtask

  initial begin
    logic [7:0] legal_ops [$];
    for (int v = 0; v < 256; v++) if (spec_legal(v[7:0])) legal_ops.push_back(v[7:0]);
    for (int a = 0; a < 65536; a++) begin
      logic [7:0] op;
      op = ($urandom_range(0, 3) != 0) ? legal_ops[$urandom_range(0, legal_ops.size() - 1)]
                                       : 8'($urandom);
      mem[a] = {op, 8'($urandom)};
    end
    mem[16'h0100] = 16'h1412; mem[16'h0101] = 16'h1410;
    mem[16'h0200] = 16'h1010; mem[16'h0201] = 16'h1234;
    mem[16'h0300] = 16'h6400; mem[16'h0301] = 16'h0500;
    mem[16'h0500] = 16'h1400;
    mem[16'hFFFF] = 16'h2000; mem[16'h0000] = 16'hABCD;
    mem[16'h0700] = 16'h9400;

    rst_n = 1'b0; start = 1'b0; start_addr = 16'h0; halt = 1'b0;
    mem_ready = 1'b0; exec_done = 1'b0; pr_load = 1'b0; pr_load_val = 16'h0;
    repeat (2) nxt();
    chk("rst.state", state, 3'b000);
    chk("rst.pr", pr, 16'h0000);
    chk("rst.mem_rd", mem_rd, 1'b0);
    chk("rst.op_code", {op_code, regs, adr, adr_en, illegal_op}, 0);
    rst_n = 1'b1;
    nxt();
    chk("idle.hold", state, 3'b000);

    // One-word fetch with two wait cycles.
    start = 1'b1; start_addr = 16'h0100;
    nxt(); start = 1'b0;
    chk("init.state", state, 3'b001);
    nxt();
    chk("ifet1.state", state, 3'b010);
    chk("ifet1.addr", mem_addr, 16'h0100);
    chk("ifet1.rd", mem_rd, 1'b1);
    nxt(); nxt();
    chk("ifet1.wait", state, 3'b010);
    mem_ready = 1'b1;
    nxt(); mem_ready = 1'b0;
    chk("t1.state", state, 3'b100);
    chk("t1.op_code", op_code, 8'h14);
    chk("t1.regs", regs, 8'h12);
    chk("t1.adr_en", adr_en, 1'b0);
    chk("t1.adr", adr, 16'h0000);
    chk("t1.pr", pr, 16'h0101);
    pr_load = 1'b1; pr_load_val = 16'hDEAD;
    nxt(); pr_load = 1'b0;
    chk("t1.prload_noexec", pr, 16'h0101);
    exec_done = 1'b1;
    nxt(); exec_done = 1'b0;
    chk("t1.wback", state, 3'b101);
    nxt();
    chk("t1.refetch", mem_addr, 16'h0101);

    // Branch into a two-word instruction.
    mem_ready = 1'b1;
    nxt(); mem_ready = 1'b0;
    exec_jump(16'h0200);
    chk("t2.addr", mem_addr, 16'h0200);
    mem_ready = 1'b1;
    nxt();
    chk("t2.ifet2", state, 3'b011);
    chk("t2.addr2", mem_addr, 16'h0201);
    nxt(); mem_ready = 1'b0;
    chk("t2.state", state, 3'b100);
    chk("t2.adr", adr, 16'h1234);
    chk("t2.adr_en", adr_en, 1'b1);
    chk("t2.pr", pr, 16'h0202);

    // JUMP 0x6400 / 0x0500.
    exec_jump(16'h0300);
    mem_ready = 1'b1;
    nxt(); nxt(); mem_ready = 1'b0;
    chk("t3.op", {op_code, adr}, 24'h640500);
    exec_jump(16'h0500);
    chk("t3.target", mem_addr, 16'h0500);

    // PR wrap: two-word at FFFF reads its address word from 0000.
    mem_ready = 1'b1;
    nxt(); mem_ready = 1'b0;
    exec_jump(16'hFFFF);
    chk("t4.addr", mem_addr, 16'hFFFF);
    mem_ready = 1'b1;
    nxt();
    chk("t4.wrap_addr", mem_addr, 16'h0000);
    nxt(); mem_ready = 1'b0;
    chk("t4.adr", adr, 16'hABCD);
    chk("t4.pr", pr, 16'h0001);

    // Illegal one-word opcode, then halt.
    exec_jump(16'h0700);
    mem_ready = 1'b1;
    nxt(); mem_ready = 1'b0;
    chk("t5.state", state, 3'b100);
    chk("t5.illegal", illegal_op, 1'b1);
    chk("t5.adr_en", adr_en, 1'b0);
    exec_done = 1'b1;
    nxt(); exec_done = 1'b0; halt = 1'b1;
    nxt(); halt = 1'b0; mem_ready = 1'b1;
    chk("t5.idle", state, 3'b000);
    nxt(); mem_ready = 1'b0;
    chk("t5.rd_low", mem_rd, 1'b0);

    // Asynchronous reset mid-IFET2, then a late mem_ready.
    start = 1'b1; start_addr = 16'h0200;
    nxt(); start = 1'b0;
    nxt(); mem_ready = 1'b1;
    nxt(); mem_ready = 1'b0;
    chk("t6.ifet2", {state, mem_rd}, {3'b011, 1'b1});
    #2 rst_n = 1'b0;
    #1;
    chk("t6.rd_drop", mem_rd, 1'b0);
    chk("t6.state", state, 3'b000);
    chk("t6.pr", pr, 16'h0000);
    mem_ready = 1'b1;
    nxt(); rst_n = 1'b1;
    nxt(); nxt(); mem_ready = 1'b0;
    chk("t6.late_ready", {state, op_code, adr, pr}, 0);

    // Randomized traffic with occasional asynchronous resets.
    for (int c = 0; c < 4000; c++) begin
      nxt();
      start       = ($urandom_range(0, 3) == 0);
      start_addr  = 16'($urandom);
      halt        = ($urandom_range(0, 5) == 0);
      mem_ready   = ($urandom_range(0, 2) == 0);
      exec_done   = ($urandom_range(0, 2) == 0);
      pr_load     = ($urandom_range(0, 1) == 0);
      pr_load_val = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        #3 rst_n = 1'b0;
        #3 rst_n = 1'b1;
      end
    end
    nxt();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
